// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    localparam logic [3:0] UART_DATA_OFS   = 4'h0;
    localparam logic [3:0] UART_STATUS_OFS = 4'h4;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    // Word index of a byte offset; only addr[3:2] takes part in decoding.
    function automatic logic [1:0] reg_index(input logic [3:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. The head entry is read
// combinationally so a consumer sees the popped word in the pop cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign rdata = mem[rd_ptr_reg];

    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// 8N1 UART transmitter behind a small CPU register window (DATA, STATUS),
// fed by a transmit FIFO.
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int CW     = $clog2(FIFO_DEPTH) + 1;
    localparam int BAUD_W = 16;
    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);

    uart_state_e       state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [7:0]        data_reg, data_next;
    logic              tx_reg, tx_next;
    logic              ovf_reg;

    logic              data_wr;
    logic              status_wr;
    logic              ovf_evt;
    logic              baud_done;
    logic              fifo_pop;
    logic [7:0]        fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [31:0]       status;
    logic              unused_bits;

    assign unused_bits = ^{addr[1:0], wdata[31:8]};

    assign data_wr   = sel && we && (addr[3:2] == reg_index(UART_DATA_OFS));
    assign status_wr = sel && we && (addr[3:2] == reg_index(UART_STATUS_OFS));
    assign ovf_evt   = data_wr && fifo_full && !fifo_pop;
    assign baud_done = (baud_reg == '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (data_wr),
        .wdata (wdata[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            data_reg  <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
        end
    end

    // tx_next is derived from the state being entered, so tx changes together
    // with the state and never glitches.
    always_comb begin
        state_next = state_reg;
        baud_next  = baud_reg;
        bit_next   = bit_reg;
        data_next  = data_reg;
        tx_next    = tx_reg;
        fifo_pop   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                baud_next = '0;
                tx_next   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    data_next  = fifo_head;
                    state_next = ST_START;
                    baud_next  = BAUD_RELOAD;
                    tx_next    = 1'b0;
                end
            end
            ST_START: begin
                if (baud_done) begin
                    state_next = ST_DATA;
                    baud_next  = BAUD_RELOAD;
                    bit_next   = '0;
                    tx_next    = data_reg[0];
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_done) begin
                    baud_next = BAUD_RELOAD;
                    if (bit_reg == 3'd7) begin
                        state_next = ST_STOP;
                        tx_next    = 1'b1;
                    end else begin
                        bit_next = bit_reg + 3'd1;
                        tx_next  = data_reg[bit_next];
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_next = 1'b1;
                if (baud_done) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        data_next  = fifo_head;
                        state_next = ST_START;
                        baud_next  = BAUD_RELOAD;
                        tx_next    = 1'b0;
                    end else begin
                        state_next = ST_IDLE;
                        baud_next  = '0;
                    end
                end else begin
                    baud_next = baud_reg - BAUD_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                baud_next  = '0;
                tx_next    = 1'b1;
            end
        endcase
    end

    // A rejected push in the same cycle as a clear leaves overflow set.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (ovf_evt) begin
            ovf_reg <= 1'b1;
        end else if (status_wr && wdata[STAT_OVF]) begin
            ovf_reg <= 1'b0;
        end
    end

    always_comb begin
        status = '0;
        status[STAT_BUSY]  = (state_reg != ST_IDLE);
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = ovf_reg;
        status[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(fifo_count);
    end

    always_comb begin
        rdata = '0;
        if (sel && (addr[3:2] == reg_index(UART_STATUS_OFS))) begin
            rdata = status;
        end
    end

    assign tx = tx_reg;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: directed scenarios plus a randomized
// run against a frame-level reference model.
module tb_uart_tx_mmio;

    localparam int CLK_DIV = 16;
    localparam int DEPTH   = 4;
    localparam int FRAME   = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        tx;

    int errors = 0;
    int checks = 0;

    // Reference model: queued bytes, sticky overflow, and position inside
    // the current frame (-1 when the line is idle).
    logic [7:0] m_q[$];
    logic       m_ovf = 1'b0;
    int         m_pos = -1;
    logic [7:0] m_cur = 8'h00;

    always #5 clk = ~clk;

    uart_tx_mmio #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .tx    (tx)
    );

    function automatic logic exp_tx();
        int idx;
        if (m_pos < 0) return 1'b1;
        idx = m_pos / CLK_DIV;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return m_cur[idx-1];
    endfunction

    function automatic logic [31:0] exp_status();
        return {24'd0, 4'(m_q.size()), m_ovf, (m_q.size() == 0),
                (m_q.size() == DEPTH), (m_pos >= 0)};
    endfunction

    function automatic logic [31:0] exp_rdata();
        if (sel && addr[3:2] == 2'b01) return exp_status();
        return 32'd0;
    endfunction

    task automatic drive(input logic r, input logic s, input logic w,
                         input logic [3:0] a, input logic [31:0] d);
        reset = r;
        sel   = s;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    // Advance the model across the coming edge, then wait past that edge.
    task automatic step();
        logic pop;
        logic ovf_evt;
        logic clr;
        ovf_evt = 1'b0;
        clr     = 1'b0;
        if (reset) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_pos = -1;
        end else begin
            pop = (m_q.size() > 0) && (m_pos < 0 || m_pos == FRAME - 1);
            if (pop) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
            end else if (m_pos == FRAME - 1) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos = m_pos + 1;
            end
            if (sel && we) begin
                $display("txn t=%0t write addr=0x%h data=0x%h", $time, addr, wdata);
                if (addr[3:2] == 2'b00) begin
                    if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
                    else ovf_evt = 1'b1;
                end else if (addr[3:2] == 2'b01 && wdata[3]) begin
                    clr = 1'b1;
                end
            end
            if (ovf_evt) m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b1, 4'h0, $urandom);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: got %b expected 1", tx);
        end
        checks++;
        if (rdata !== 32'h0000_0004) begin
            errors++;
            $display("FAIL reset_status: got 0x%h expected 0x00000004", rdata);
        end
        step();
        checks++;
        if (rdata !== 32'h0000_0004 || tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_write_ignored: got status 0x%h tx %b expected 0x00000004 tx 1", rdata, tx);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       e;
        b = 8'h55;
        drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_0055);
        step();
        for (int k = 1; k <= 170; k++) begin
            drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
            step();
            if (k <= 16) e = 1'b0;
            else if (k <= 144) e = b[(k - 17) / 16];
            else e = 1'b1;
            checks++;
            if (tx !== e) begin
                errors++;
                $display("FAIL frame55_tx[%0d]: got %b expected %b", k, tx, e);
            end
            if (k == 160) begin
                checks++;
                if (rdata[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame55_busy_end: got %b expected 1", rdata[0]);
                end
            end
            if (k == 161) begin
                checks++;
                if (rdata !== 32'h0000_0004) begin
                    errors++;
                    $display("FAIL frame55_idle: got 0x%h expected 0x00000004", rdata);
                end
            end
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'h0, {24'd0, 8'($urandom)});
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0000_004B) begin
            errors++;
            $display("FAIL ovf_status: got 0x%h expected 0x0000004b", rdata);
        end
        drive(1'b0, 1'b1, 1'b1, 4'h4, 32'h8);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0000_0043) begin
            errors++;
            $display("FAIL ovf_clear: got 0x%h expected 0x00000043", rdata);
        end
        drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_00EE);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0000_004B) begin
            errors++;
            $display("FAIL ovf_reject_full: got 0x%h expected 0x0000004b", rdata);
        end
        drive(1'b0, 1'b1, 1'b1, 4'h4, 32'h8);
        step();
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        for (int k = 0; k < 5 * FRAME + 20; k++) begin
            checks++;
            if (tx !== exp_tx()) begin
                errors++;
                $display("FAIL b2b_tx[%0d]: got %b expected %b", k, tx, exp_tx());
            end
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0000_0004) begin
            errors++;
            $display("FAIL b2b_drained: got 0x%h expected 0x00000004", rdata);
        end
    endtask

    task automatic test_midframe_reset();
        drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_00A3);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b1, 1'b1, 4'h0, {24'd0, 8'($urandom)});
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 4'h0, 32'd0);
        for (int k = 0; k < 40; k++) begin
            step();
            checks++;
            if (tx !== exp_tx()) begin
                errors++;
                $display("FAIL mid_pre_tx[%0d]: got %b expected %b", k, tx, exp_tx());
            end
        end
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (tx !== 1'b1 || rdata !== 32'h0000_0004) begin
            errors++;
            $display("FAIL mid_reset: got tx %b status 0x%h expected tx 1 status 0x00000004", tx, rdata);
        end
        for (int k = 0; k < 2 * FRAME; k++) begin
            step();
            checks++;
            if (tx !== 1'b1) begin
                errors++;
                $display("FAIL mid_no_frames[%0d]: got %b expected 1", k, tx);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [3:0] a;
        drive(1'b0, 1'b1, 1'b1, 4'h8, $urandom);
        step();
        drive(1'b0, 1'b1, 1'b1, 4'hC, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b1, 1'b0, 4'h4, 32'd0);
        #1;
        checks++;
        if (rdata !== 32'h0000_0004) begin
            errors++;
            $display("FAIL unmapped_write_ignored: got 0x%h expected 0x00000004", rdata);
        end
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 4'h8 : (i == 1) ? 4'hC : 4'h0;
            drive(1'b0, 1'b1, 1'b0, a, 32'd0);
            #1;
            checks++;
            if (rdata !== 32'd0) begin
                errors++;
                $display("FAIL read_zero_0x%h: got 0x%h expected 0", a, rdata);
            end
        end
        drive(1'b0, 1'b1, 1'b1, 4'h0, 32'h0000_005A);
        step();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'($urandom), 4'($urandom), $urandom);
            #1;
            checks++;
            if (rdata !== 32'd0) begin
                errors++;
                $display("FAIL nosel_read: got 0x%h expected 0", rdata);
            end
            drive(1'b0, 1'b0, 1'b0, 4'h4, 32'd0);
            step();
        end
        for (int k = 0; k < FRAME; k++) step();
    endtask

    task automatic test_random();
        int r;
        for (int k = 0; k < 5000; k++) begin
            r = $urandom_range(0, 999);
            if (r < 3) drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
            else if (r < 23) drive(1'b0, 1'b1, 1'b1, 4'h0, $urandom);
            else if (r < 33) drive(1'b0, 1'b1, 1'b1, 4'h4, $urandom);
            else if (r < 40) drive(1'b0, 1'b1, 1'b1, {2'b1, 2'($urandom)}, $urandom);
            else if (r < 500) drive(1'b0, 1'b1, 1'b0, 4'($urandom), 32'd0);
            else drive(1'b0, 1'b0, 1'b0, 4'($urandom), 32'd0);
            #1;
            checks++;
            if (tx !== exp_tx() || rdata !== exp_rdata()) begin
                errors++;
                $display("FAIL rand[%0d]: got tx %b rdata 0x%h expected tx %b rdata 0x%h",
                         k, tx, rdata, exp_tx(), exp_rdata());
            end
            step();
        end
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 4'h0, 32'd0);
        test_reset();
        test_single_frame();
        test_overflow();
        test_midframe_reset();
        test_unmapped();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio.md
UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 16, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries (power of two, at least 2).
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: synchronous, active-high reset.
REQ-005 The block SHALL have port sel, input, width 1: the CPU data-bus access targets this block.
REQ-006 The block SHALL have port we, input, width 1: store strobe, sampled at the clk edge when sel=1.
REQ-007 The block SHALL have port addr, input, width 4: byte offset; only addr[3:2] decoded.
REQ-008 The block SHALL have port wdata, input, width 32: store data.
REQ-009 The block SHALL have port rdata, output, width 32: combinational load data, valid the same cycle as sel/addr.
REQ-010 The block SHALL have port tx, output, width 1: serial line, idle high.

Function
REQ-011 Register map SHALL be: offset 0x0 DATA (write-only, reads 0); offset 0x4 STATUS; offsets 0x8 and 0xC read 0, ignore writes.
REQ-012 STATUS SHALL read as: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[7:4] FIFO count, other bits 0.
REQ-013 rdata SHALL be 0 when sel=0.
REQ-014 A write to DATA (sel & we) SHALL push wdata[7:0]; a push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
REQ-015 A rejected push SHALL leave the FIFO unchanged and set overflow.
REQ-016 A STATUS write with wdata[3]=1 SHALL clear overflow; a same-cycle overflow event takes priority (overflow stays 1).
REQ-017 The FSM SHALL have states IDLE, START, DATA, STOP, each bit period lasting exactly CLK_DIV cycles.
REQ-018 In IDLE with FIFO non-empty, the FSM SHALL pop one byte and enter START at the next edge, so tx goes low one cycle after the push edge.
REQ-019 DATA SHALL shift 8 bits LSB first, and a 3-bit counter SHALL select the bit.
REQ-020 STOP SHALL drive tx=1; on its last cycle the FSM SHALL pop and enter START if the FIFO is non-empty, otherwise go to IDLE, giving back-to-back frames of exactly 10*CLK_DIV cycles.
REQ-021 tx SHALL be registered (glitch-free): 1 in IDLE/STOP, 0 in START, the data bit in DATA.
REQ-022 The baud counter SHALL reload at every state entry and never free-run in IDLE.

Reset
REQ-023 While reset=1 at an edge, the block SHALL set state=IDLE, tx=1, FIFO empty (pointers 0, count 0), overflow=0, baud and bit counters 0.
REQ-024 Reset mid-frame SHALL abort the frame: tx=1 from the cycle after the reset edge and queued bytes discarded.
REQ-025 Bus writes coincident with reset SHALL be ignored.

Structure
REQ-026 A shared package uart_pkg SHALL hold the state enum type, register offset constants (UART_DATA_OFS=0x0, UART_STATUS_OFS=0x4) and STATUS bit-index constants.
REQ-027 The FIFO SHALL be a sub-module sync_fifo (parameterised width/depth, push/pop/full/empty/count, same reset).

Verification (CLK_DIV=16, FIFO_DEPTH=4)
REQ-028 Write 0x55 to 0x0 at edge N -> tx=0 during cycles N+1..N+16, then 1,0,1,0,1,0,1,0 each for 16 cycles, then stop 1 for 16; busy=0 after cycle N+160.
REQ-029 Six DATA writes on consecutive edges while idle -> first five transmitted in order with no gap (frames of 160 cycles); sixth dropped; STATUS reads 0x0000_004B (count=4, overflow, full, busy) immediately after.
REQ-030 After REQ-029, write 0x8 to 0x4 -> overflow=0; a same-cycle rejected push with the clear -> overflow stays 1.
REQ-031 Reset asserted mid-DATA of byte 0xA3 with 2 bytes queued -> tx=1 next cycle, STATUS reads 0x0000_0004, no further frames.
REQ-032 Read 0x8, 0xC, and 0x0 -> rdata=0; sel=0 with any addr -> rdata=0.
